// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
//   N_REQ   : number of requesters
//   IDX_W   : width of a requester index
//   state_e : arbiter state (IDLE, GRANT)
//   pick_t  : result of a circular priority search (found flag + index)
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

endpackage

// File: rtl/arb4_rr_decoder2to4.sv
// 2:4 decoder with enable, driving the one-hot grant vector.
//   in  : 2-bit select
//   en  : enable; out is all-zero when low
//   out : one-hot decode of in when en is high
module decoder2to4
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] in,
  input  logic             en,
  output logic [N_REQ-1:0] out
);

  always_comb begin
    out = '0;
    if (en) begin
      out[in] = 1'b1;
    end
  end

endmodule

// File: rtl/arb4_rr.sv
// Four-requester round-robin arbiter. Owns a shared resource on behalf of
// one requester at a time, holds the grant while the owner keeps requesting
// (up to MAX_HOLD cycles), then rotates priority and hands off back-to-back
// when another request is pending.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   req : level-sensitive request vector, one bit per requester
//   sel : registered index of the granted requester
//   en  : registered grant valid
//   gnt : one-hot grant, decode(sel) when en is high, else zero
module arb4_rr
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] sel,
  output logic             en,
  output logic [N_REQ-1:0] gnt
);

  localparam int unsigned     CNT_W    = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  // First set bit of r in circular order start, start+1, ... (mod N_REQ).
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] r,
                                    input logic [IDX_W-1:0] start);
    pick_t            p;
    logic [IDX_W-1:0] idx;
    p = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = start + IDX_W'(i);
      if (!p.found && r[idx]) begin
        p.found = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] sel_q,   sel_d;
  logic             en_q,    en_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic [IDX_W-1:0] sel_nxt;
  pick_t            pick_idle;
  pick_t            pick_rel;
  logic             hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      en_q    <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel_nxt   = sel_q + IDX_W'(1);
  assign pick_idle = rr_pick(req, ptr_q);
  // Searching from sel+1 puts the current owner last, so a sole requester
  // at timeout is simply re-granted with a fresh count.
  assign pick_rel  = rr_pick(req, sel_nxt);
  assign hold      = req[sel_q] && (cnt_q < CNT_LAST);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (pick_idle.found) begin
          sel_d   = pick_idle.idx;
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end

      GRANT: begin
        if (hold) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          ptr_d = sel_nxt;
          cnt_d = '0;
          if (pick_rel.found) begin
            sel_d = pick_rel.idx;
            en_d  = 1'b1;
          end else begin
            en_d    = 1'b0;
            state_d = IDLE;
          end
        end
      end

      default: begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign sel = sel_q;
  assign en  = en_q;

  decoder2to4 u_dec (
    .in  (sel_q),
    .en  (en_q),
    .out (gnt)
  );

endmodule

// File: tb/tb_arb4_rr.sv
// Bench for arb4_rr: two instances (MAX_HOLD = 4 and MAX_HOLD = 1) share the
// same stimulus; a per-instance behavioural model tracks owner, cycles held
// and priority pointer, and is compared on every cycle. Directed sequences
// pin the model with literal expectations, followed by random traffic.
module tb_arb4_rr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b1111;

  logic [1:0] sel4, sel1;
  logic       en4,  en1;
  logic [3:0] gnt4, gnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arb4_rr #(.MAX_HOLD(4)) u4 (
    .clk (clk), .rst (rst), .req (req), .sel (sel4), .en (en4), .gnt (gnt4)
  );

  arb4_rr #(.MAX_HOLD(1)) u1 (
    .clk (clk), .rst (rst), .req (req), .sel (sel1), .en (en1), .gnt (gnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mh[2] = '{4, 1};
  int owner[2];      // -1 when nobody holds the resource
  int held[2];       // cycles the current owner has been shown its grant
  int ptr[2];
  int selexp[2];
  bit selknown[2];
  bit armed = 1'b0;

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int w;
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        owner[u] = -1; held[u] = 0; ptr[u] = 0; selexp[u] = 0; selknown[u] = 1'b1;
      end else if (owner[u] < 0) begin
        w = first_from(req, ptr[u]);
        if (w >= 0) begin
          owner[u] = w; held[u] = 1; selexp[u] = w; selknown[u] = 1'b1;
        end
      end else if (req[owner[u]] && held[u] < mh[u]) begin
        held[u] = held[u] + 1;
      end else begin
        ptr[u] = (owner[u] + 1) % 4;
        w = first_from(req, ptr[u]);
        if (w >= 0) begin
          owner[u] = w; held[u] = 1; selexp[u] = w; selknown[u] = 1'b1;
        end else begin
          owner[u] = -1; held[u] = 0; selknown[u] = 1'b0;
        end
      end
    end
    if (rst) armed = 1'b1;
  end

  always @(negedge clk) begin : compare
    logic [1:0] s;
    logic       e;
    logic [3:0] g;
    logic [3:0] eg;
    if (armed) begin
      for (int u = 0; u < 2; u++) begin
        s = (u == 0) ? sel4 : sel1;
        e = (u == 0) ? en4  : en1;
        g = (u == 0) ? gnt4 : gnt1;
        eg = (owner[u] >= 0) ? (4'b0001 << owner[u]) : 4'b0000;
        chk($sformatf("model_en_mh%0d", mh[u]), 32'(e), 32'(owner[u] >= 0));
        chk($sformatf("model_gnt_mh%0d", mh[u]), 32'(g), 32'(eg));
        if (selknown[u]) chk($sformatf("model_sel_mh%0d", mh[u]), 32'(s), 32'(selexp[u]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    bit found;

    // Reset held two cycles with all requests high.
    rst = 1'b1; req = 4'b1111;
    tick();
    chk("rst_en_a", 32'(en4), 32'd0);
    chk("rst_gnt_a", 32'(gnt4), 32'h0);
    tick();
    chk("rst_en_b", 32'(en4), 32'd0);
    chk("rst_sel_b", 32'(sel4), 32'd0);
    chk("rst_gnt_b", 32'(gnt4), 32'h0);

    // Full rotation: MAX_HOLD=4 holds 4 cycles each, MAX_HOLD=1 rotates every cycle.
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      tick();
      chk($sformatf("rot4_%0d", i), 32'(gnt4), 32'(4'b0001 << ((i / 4) % 4)));
      chk($sformatf("rot1_%0d", i), 32'(gnt1), 32'(4'b0001 << (i % 4)));
      chk($sformatf("rot4_en_%0d", i), 32'(en4), 32'd1);
    end

    // Reset in the middle of the requester-2 grant.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (gnt4 == 4'b0100) found = 1'b1;
      else tick();
    end
    chk("midgrant_reached", 32'(found), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_en", 32'(en4), 32'd0);
    chk("midrst_gnt", 32'(gnt4), 32'h0);
    rst = 1'b0;
    tick();
    chk("midrst_next", 32'(gnt4), 32'h1);

    // Single request, then pointer check.
    rst = 1'b1; req = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
    req = 4'b0100;
    tick();
    chk("single_sel", 32'(sel4), 32'd2);
    chk("single_en", 32'(en4), 32'd1);
    chk("single_gnt", 32'(gnt4), 32'h4);
    req = 4'b0000;
    tick();
    chk("single_drop_en", 32'(en4), 32'd0);
    chk("single_drop_gnt", 32'(gnt4), 32'h0);
    req = 4'b1001;
    tick();
    chk("ptr_after_single", 32'(gnt4), 32'h8);

    // Fairness.
    req = 4'b0001;
    tick();
    chk("fair_req0", 32'(gnt4), 32'h1);
    req = 4'b0000;
    tick();
    chk("fair_idle", 32'(en4), 32'd0);
    req = 4'b0011;
    tick();
    chk("fair_first", 32'(gnt4), 32'h2);
    req = 4'b0001;
    tick();
    chk("fair_second", 32'(gnt4), 32'h1);
    chk("fair_no_gap", 32'(en4), 32'd1);

    // Sole requester beyond the hold limit.
    req = 4'b0000;
    tick();
    req = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("sole4_%0d", i), 32'(gnt4), 32'h8);
      chk($sformatf("sole1_%0d", i), 32'(gnt1), 32'h8);
      chk($sformatf("sole4_en_%0d", i), 32'(en4), 32'd1);
    end

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 7) == 0) req[$urandom_range(0, 3)] = 1'b0;
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb4_rr.md
# arb4_rr

Four-requester round-robin arbiter that sequences a shared resource by driving the select and enable inputs of a 2:4 decoder. Each cycle it decides which requester owns the resource, holds that grant for as long as the requester needs it (bounded by a hold limit), then rotates priority. The decoder output is the one-hot grant vector returned to the requesters.

## Interface
- MAX_HOLD, 8: maximum consecutive cycles a single grant may be held; legal range ≥ 1.
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-high
- req  in  4  request vector, one bit per requester; level-sensitive
- sel  out  2  index of the granted requester (registered)
- en  out  1  grant valid (registered)
- gnt  out  4  one-hot grant, equal to decode(sel) when en = 1 and 0000 when en = 0

## Operation
- State machine has two states: IDLE and GRANT.
- Internal `ptr[1:0]` holds the highest-priority index; search order is ptr, ptr+1, … mod 4.
- Internal `cnt` counts cycles of the current grant; width is $clog2(MAX_HOLD)+1.
- **IDLE**
  - en = 0.
  - When req ≠ 0000, the winner is the first set bit in circular order starting at ptr.
  - On that edge: sel ← winner, en ← 1, cnt ← 0, next state GRANT.
- **GRANT, hold condition:** stay while req[sel] = 1 and cnt < MAX_HOLD-1; cnt increments each cycle.
- **GRANT, release condition:** release on the edge where req[sel] = 0 or cnt = MAX_HOLD-1. On release:
  - ptr ← sel+1 mod 4 (3 wraps to 0).
  - Search req in order sel+1, sel+2, sel+3, then sel itself last.
  - If a winner is found: sel ← winner, cnt ← 0, en stays 1, state stays GRANT. This is a back-to-back handoff with no idle cycle.
  - If no winner is found: en ← 0 and next state IDLE.
- **Sole requester at timeout:** it is re-granted immediately. gnt stays continuous and cnt restarts.
- **MAX_HOLD = 1:** every grant lasts exactly one cycle, so with several requesters active the grant rotates every cycle.
- **Requests arriving mid-grant:** have no effect until release.
- **Reset:** rst = 1 at an edge gives state IDLE, sel = 00, en = 0, gnt = 0000, ptr = 00, cnt = 0. This applies in any state, including mid-grant.
- **Reset priority:** rst has priority over all other inputs on the same edge.

## Timing
- All state is updated on the rising edge of clk only.
- sel and en are registered; gnt is combinational from the registered sel/en through the decoder, so it is glitch-free.
- **Grant latency:** req sampled at edge k in IDLE → sel/en/gnt valid immediately after edge k (one cycle from assertion).
- **Release latency:** req[sel] sampled low at edge k → the grant moves or drops after edge k. The requester therefore sees its grant for the cycle in which it deasserted.
- **Timeout:** a continuously requesting owner with competitors present holds the grant for exactly MAX_HOLD cycles.
- **After reset release:** the first grant can appear after the first edge with rst = 0.

## Structure
- Shared package `arb_pkg` contains:
  - the state enum (IDLE, GRANT);
  - the constant N_REQ = 4;
  - the index width constant IDX_W = 2.
- One sub-module: the existing `decoder2to4` (ports in, en, out), instantiated with in = sel, en = en, out = gnt.
- The circular priority search is a combinational function inside arb4_rr.

## Test plan
- **Reset:** rst = 1 for 2 cycles with req = 1111 → en = 0, sel = 00, gnt = 0000 throughout. After rst = 0, the first edge gives gnt = 0001.
- **Single request:** from IDLE, req = 0100 → next edge sel = 10, en = 1, gnt = 0100. Then req = 0000 → next edge en = 0, gnt = 0000, and ptr = 11 (checked when req = 1001 next grants 1000).
- **Full rotation with MAX_HOLD = 4, req = 1111 held:** gnt = 0001 for 4 cycles, then 0010 ×4, 0100 ×4, 1000 ×4, then 0001. Handoffs have no en = 0 gap and wrap 3 → 0.
- **Fairness:**
  - req0 granted and released.
  - Then req = 0011 arrives in IDLE → gnt = 0010 first.
  - On release with req0 still high → gnt = 0001 on the next edge.
- **Sole requester timeout, MAX_HOLD = 4:** req = 1000 held for 10 cycles → gnt = 1000 continuous for all 10 cycles, en never drops.
- **Reset mid-grant:** during gnt = 0100, assert rst for 1 cycle with req = 1111 → en = 0, gnt = 0000 after that edge. After release the next grant is 0001 because ptr was reset.
